// File: rtl/term_cmd_parser_pkg.sv
// ---------------------------------------------------------------------------
// term_cmd_parser_pkg
//   Shared definitions for the terminal command parser: ASCII control byte
//   constants, the parser FSM state encoding and the default op_code width.
// ---------------------------------------------------------------------------
package term_cmd_parser_pkg;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    // Letters 'A'..'K' -> one-hot bits 0..10
    localparam int N_OPS_DEFAULT = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,  // waiting for the command letter
        ST_OP     = 3'd1,  // letter seen
        ST_SP     = 3'd2,  // letter + space seen, a hex digit must follow
        ST_HEX2   = 3'd3,  // one hex digit held in hi
        ST_WAIT_T = 3'd4,  // two hex digits held, only a terminator is legal
        ST_FLUSH  = 3'd5   // line is malformed, discard up to the terminator
    } state_t;

endpackage

// File: rtl/term_cmd_parser_if.sv
// ---------------------------------------------------------------------------
// term_cmd_parser_if
//   Byte streams around the parser.
//   rx_*   : received byte stream, rx_valid is a 1-cycle strobe, no backpressure.
//   echo_* : echo byte channel. A byte moves on a rising clock edge where
//            echo_valid & echo_ready are both 1; echo_data is stable while
//            echo_valid=1 and echo_ready=0. echo_drop is a 1-cycle pulse
//            reporting an rx byte that could not be echoed.
//   master : terminal / TX side (drives rx, echo_ready)
//   slave  : parser side
// ---------------------------------------------------------------------------
interface term_cmd_parser_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       echo_valid;
    logic [7:0] echo_data;
    logic       echo_ready;
    logic       echo_drop;

    modport master (
        output rx_valid, rx_data, echo_ready,
        input  echo_valid, echo_data, echo_drop
    );

    modport slave (
        input  rx_valid, rx_data, echo_ready,
        output echo_valid, echo_data, echo_drop
    );

endinterface

// File: rtl/term_cmd_parser_classify.sv
// ---------------------------------------------------------------------------
// ascii_classify
//   Purely combinational classification of one received byte.
//   i_data         : received ASCII byte
//   o_is_hex       : byte is 0-9 / A-F / a-f
//   o_nibble       : value of the hex digit (0 when not hex)
//   o_is_op_letter : byte is a command letter whose index is below N_OPS
//   o_op_idx       : letter index, 'A'/'a' -> 0 (0 when not a command letter)
//   o_is_term      : CR or LF
//   o_is_bs        : backspace or DEL
// ---------------------------------------------------------------------------
module ascii_classify
    import term_cmd_parser_pkg::*;
#(
    parameter int N_OPS = N_OPS_DEFAULT
) (
    input  logic [7:0] i_data,
    output logic       o_is_hex,
    output logic [3:0] o_nibble,
    output logic       o_is_op_letter,
    output logic [3:0] o_op_idx,
    output logic       o_is_term,
    output logic       o_is_bs
);

    logic [7:0] w_upper;
    logic [7:0] w_off;
    logic       w_is_letter;

    always_comb begin
        // Fold lower case onto upper case so one range check serves both
        w_upper = ((i_data >= 8'h61) && (i_data <= 8'h7A)) ? (i_data - 8'h20) : i_data;
        w_off       = w_upper - 8'h41;
        w_is_letter = (w_upper >= 8'h41) && (w_upper <= 8'h5A);

        o_is_hex = 1'b0;
        o_nibble = 4'h0;
        if ((i_data >= 8'h30) && (i_data <= 8'h39)) begin
            o_is_hex = 1'b1;
            o_nibble = i_data[3:0];
        end else if ((w_upper >= 8'h41) && (w_upper <= 8'h46)) begin
            // 'A' is 0x41, so the low nibble plus 9 gives 10..15
            o_is_hex = 1'b1;
            o_nibble = w_upper[3:0] + 4'd9;
        end

        o_is_op_letter = w_is_letter && (w_off < 8'(N_OPS));
        o_op_idx       = o_is_op_letter ? w_off[3:0] : 4'd0;
        o_is_term      = (i_data == ASCII_CR) || (i_data == ASCII_LF);
        o_is_bs        = (i_data == ASCII_BS) || (i_data == ASCII_DEL);
    end

endmodule

// File: rtl/term_cmd_parser.sv
// ---------------------------------------------------------------------------
// term_cmd_parser
//   Parses one-line terminal commands "<L>[ <h>[<h>]]<CR|LF>" from the UART RX
//   byte stream and holds the resulting one-hot op_code and operand a for the
//   VGA command stage. Optionally echoes received bytes to the TX side.
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : rx byte stream and echo channel (slave modport)
//   op_code     : one-hot command, held until the next committed command
//   a           : operand, held with op_code
//   cmd_strobe  : 1-cycle pulse when op_code/a update
//   err         : 1-cycle pulse when a malformed line is terminated
//   busy        : a line is partially received
//   dbg_state   : current parser state
// ---------------------------------------------------------------------------
module term_cmd_parser
    import term_cmd_parser_pkg::*;
#(
    parameter int N_OPS   = N_OPS_DEFAULT,
    parameter bit ECHO_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    term_cmd_parser_if.slave     bus,
    output logic [N_OPS-1:0]     op_code,
    output logic [7:0]           a,
    output logic                 cmd_strobe,
    output logic                 err,
    output logic                 busy,
    output state_t               dbg_state
);

    logic       w_is_hex;
    logic [3:0] w_nibble;
    logic       w_is_op_letter;
    logic [3:0] w_op_idx;
    logic       w_is_term;
    logic       w_is_bs;

    ascii_classify #(.N_OPS(N_OPS)) u_classify (
        .i_data         (bus.rx_data),
        .o_is_hex       (w_is_hex),
        .o_nibble       (w_nibble),
        .o_is_op_letter (w_is_op_letter),
        .o_op_idx       (w_op_idx),
        .o_is_term      (w_is_term),
        .o_is_bs        (w_is_bs)
    );

    state_t           r_state;
    logic [3:0]       r_idx;
    logic [3:0]       r_hi;
    logic [3:0]       r_lo;
    logic [N_OPS-1:0] r_op_code;
    logic [7:0]       r_a;
    logic             r_cmd_strobe;
    logic             r_err;

    state_t           w_state_nx;
    logic [3:0]       w_idx_nx;
    logic [3:0]       w_hi_nx;
    logic [3:0]       w_lo_nx;
    logic             w_commit;
    logic             w_error;
    logic [7:0]       w_operand;
    logic [N_OPS-1:0] w_onehot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_hi    <= 4'd0;
            r_lo    <= 4'd0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        w_commit   = 1'b0;
        w_error    = 1'b0;
        w_operand  = 8'h00;

        if (bus.rx_valid) begin
            if (w_is_bs) begin
                // Backspace abandons the line silently from any state
                w_state_nx = ST_IDLE;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_is_op_letter) begin
                            w_idx_nx   = w_op_idx;
                            w_state_nx = ST_OP;
                        end else if (!w_is_term) begin
                            // Terminators here are blank lines (or the LF of CR-LF)
                            w_state_nx = ST_FLUSH;
                        end
                    end
                    ST_OP: begin
                        if (bus.rx_data == ASCII_SP) begin
                            w_state_nx = ST_SP;
                        end else if (w_is_term) begin
                            w_commit   = 1'b1;
                            w_operand  = 8'h00;
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_state_nx = ST_FLUSH;
                        end
                    end
                    ST_SP: begin
                        if (w_is_hex) begin
                            w_hi_nx    = w_nibble;
                            w_state_nx = ST_HEX2;
                        end else if (w_is_term) begin
                            // A space promises an operand; ending here is malformed
                            w_error    = 1'b1;
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_state_nx = ST_FLUSH;
                        end
                    end
                    ST_HEX2: begin
                        if (w_is_hex) begin
                            w_lo_nx    = w_nibble;
                            w_state_nx = ST_WAIT_T;
                        end else if (w_is_term) begin
                            w_commit   = 1'b1;
                            w_operand  = {4'h0, r_hi};
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_state_nx = ST_FLUSH;
                        end
                    end
                    ST_WAIT_T: begin
                        if (w_is_term) begin
                            w_commit   = 1'b1;
                            w_operand  = {r_hi, r_lo};
                            w_state_nx = ST_IDLE;
                        end else begin
                            w_state_nx = ST_FLUSH;
                        end
                    end
                    ST_FLUSH: begin
                        if (w_is_term) begin
                            w_error    = 1'b1;
                            w_state_nx = ST_IDLE;
                        end
                    end
                    default: begin
                        w_state_nx = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_code    <= '0;
            r_a          <= 8'h00;
            r_cmd_strobe <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_cmd_strobe <= w_commit;
            r_err        <= w_error;
            if (w_commit) begin
                r_op_code <= w_onehot;
                r_a       <= w_operand;
            end
        end
    end

    assign op_code    = r_op_code;
    assign a          = r_a;
    assign cmd_strobe = r_cmd_strobe;
    assign err        = r_err;
    assign busy       = (r_state != ST_IDLE);
    assign dbg_state  = r_state;

    // Single-entry echo register, independent of the parser
    if (ECHO_EN) begin : g_echo
        logic       r_echo_valid;
        logic [7:0] r_echo_data;
        logic       r_echo_drop;
        logic       w_drain;

        assign w_drain = r_echo_valid & bus.echo_ready;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_echo_valid <= 1'b0;
                r_echo_data  <= 8'h00;
                r_echo_drop  <= 1'b0;
            end else begin
                r_echo_drop <= 1'b0;
                if (bus.rx_valid) begin
                    if (!r_echo_valid || w_drain) begin
                        r_echo_valid <= 1'b1;
                        r_echo_data  <= bus.rx_data;
                    end else begin
                        // Register still full: keep the held byte, report the loss
                        r_echo_drop <= 1'b1;
                    end
                end else if (w_drain) begin
                    r_echo_valid <= 1'b0;
                end
            end
        end

        assign bus.echo_valid = r_echo_valid;
        assign bus.echo_data  = r_echo_data;
        assign bus.echo_drop  = r_echo_drop;
    end else begin : g_no_echo
        assign bus.echo_valid = 1'b0;
        assign bus.echo_data  = 8'h00;
        assign bus.echo_drop  = 1'b0;
    end

endmodule

// File: tb/tb_term_cmd_parser.sv
module tb_term_cmd_parser;
    import term_cmd_parser_pkg::*;

    localparam int N = 11;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] op_code;
    logic [7:0]   a;
    logic         cmd_strobe;
    logic         err;
    logic         busy;
    state_t       dbg_state;

    term_cmd_parser_if bus();

    term_cmd_parser #(.N_OPS(N), .ECHO_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .op_code    (op_code),
        .a          (a),
        .cmd_strobe (cmd_strobe),
        .err        (err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_bad  = 0;
    int n_drop = 0;
    // {cmd_strobe, err, op_code, a} expected at each strobe/err event
    logic [20:0] exp_q[$];
    logic [7:0]  echo_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] b, input bit echo_exp);
        if (echo_exp) echo_q.push_back(b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [N-1:0] op, input logic [7:0] av);
        exp_q.push_back({1'b1, 1'b0, op, av});
    endtask

    task automatic push_err(input logic [N-1:0] op, input logic [7:0] av);
        exp_q.push_back({1'b0, 1'b1, op, av});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_strobe || err) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got strobe=%b err=%b op=0x%0h a=0x%0h, expected no event",
                             cmd_strobe, err, op_code, a);
                end else begin
                    check("cmd_event", 32'({cmd_strobe, err, op_code, a}), 32'(exp_q.pop_front()));
                end
            end
            if (bus.echo_valid && bus.echo_ready) begin
                if (echo_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_echo: got 0x%0h, expected no echo", bus.echo_data);
                end else begin
                    check("echo_byte", 32'(bus.echo_data), 32'(echo_q.pop_front()));
                end
            end
            if (bus.echo_drop) n_drop++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset          = 1'b1;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.echo_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_op_code", 32'(op_code), 32'h0);
        check("rst_a", 32'(a), 32'h0);
        check("rst_strobe", 32'(cmd_strobe), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_echo_valid", 32'(bus.echo_valid), 32'h0);
        check("rst_echo_drop", 32'(bus.echo_drop), 32'h0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // 1: two-digit operand
        send_str("B 3F");
        check("t1_busy_mid_line", 32'(busy), 32'h1);
        push_cmd(11'h002, 8'h3F);
        send(ASCII_CR, 1'b1);
        @(negedge clk);
        check("t1_strobe", 32'(cmd_strobe), 32'h1);
        @(negedge clk);
        check("t1_strobe_one_cycle", 32'(cmd_strobe), 32'h0);
        check("t1_op_hold", 32'(op_code), 32'h002);
        idle(1);

        // 2: lower-case letter, CR LF pair gives one commit
        push_cmd(11'h400, 8'h00);
        send_str("k");
        send(ASCII_CR, 1'b1);
        send(ASCII_LF, 1'b1);
        idle(3);

        // 3: single digit commit, then two malformed lines
        push_cmd(11'h004, 8'h07);
        send_str("C 7");
        send(ASCII_CR, 1'b1);
        push_err(11'h004, 8'h07);
        send_str("Z 12");
        send(ASCII_CR, 1'b1);
        push_err(11'h004, 8'h07);
        send_str("D ");
        send(ASCII_CR, 1'b1);
        idle(2);
        check("t3_op_hold", 32'(op_code), 32'h004);
        check("t3_a_hold", 32'(a), 32'h07);

        // 4: backspace aborts a partial line
        send_str("A 1");
        send(ASCII_BS, 1'b1);
        check("t4_busy_after_bs", 32'(busy), 32'h0);
        push_cmd(11'h008, 8'h55);
        send_str("D 55");
        send(ASCII_CR, 1'b1);
        idle(2);

        // Extra: lower-case hex, mixed case, DEL abort, letter beyond N_OPS
        push_cmd(11'h002, 8'h0C);
        send_str("b c");
        send(ASCII_CR, 1'b1);
        push_cmd(11'h200, 8'hAB);
        send_str("j aB");
        send(ASCII_LF, 1'b1);
        send_str("G 9");
        send(ASCII_DEL, 1'b1);
        push_err(11'h200, 8'hAB);
        send_str("L");
        send(ASCII_CR, 1'b1);
        idle(2);
        check("ext_op_hold", 32'(op_code), 32'h200);
        check("ext_a_hold", 32'(a), 32'hAB);

        // 5: echo register full, later bytes dropped
        bus.echo_ready = 1'b0;
        n_drop = 0;
        send(8'h45, 1'b1);   // 'E' is loaded
        send(8'h20, 1'b0);   // dropped
        send(8'h34, 1'b0);   // dropped
        @(negedge clk);
        #1;
        check("t5_drop_count", 32'(n_drop), 32'd2);
        check("t5_echo_valid", 32'(bus.echo_valid), 32'h1);
        check("t5_echo_data_held", 32'(bus.echo_data), 32'h45);
        check("t5_busy", 32'(busy), 32'h1);
        @(posedge clk);
        #1;
        bus.echo_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t5_echo_drained", 32'(bus.echo_valid), 32'h0);
        check("t5_echo_q_empty", 32'(echo_q.size()), 32'd0);

        // 6: reset mid-line clears everything
        reset = 1'b1;
        #2;
        check("t6_rst_op_code", 32'(op_code), 32'h0);
        check("t6_rst_a", 32'(a), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_strobe", 32'(cmd_strobe), 32'h0);
        check("t6_rst_echo_valid", 32'(bus.echo_valid), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        push_cmd(11'h020, 8'h00);
        send_str("F");
        send(ASCII_CR, 1'b1);
        idle(3);
        check("t6_op_code", 32'(op_code), 32'h020);
        check("t6_a", 32'(a), 32'h00);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("echo_q_drained", 32'(echo_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
